// File: rtl/slc3_pkg.sv
// rtl/slc3_pkg.sv - SLC-3 control unit state encoding, opcodes and mux encodings
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT,
        S_BR_CHK, S_BR_TAKE, S_JMP, S_JSR1, S_JSR2,
        S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3
`ifdef SLC3_PAUSE_EN
        , S_PAUSE1, S_PAUSE2
`endif
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_ADDER = 2'd1;
    localparam logic [1:0] PCMUX_BUS   = 2'd2;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic       ADDR1_PC    = 1'b0;
    localparam logic       ADDR1_BASER = 1'b1;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_NOT   = 2'd2;
    localparam logic [1:0] ALU_PASSA = 2'd3;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_F2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/slc3_mem_wait.sv
// rtl/slc3_mem_wait.sv - memory access dwell counter for the SLC-3 control unit
module slc3_mem_wait #(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset_al,
    input  logic start,
    output logic done
);

    localparam logic [2:0] LOAD_VAL = 3'(MEM_WAIT - 1);

    logic [2:0] cnt;

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al)
            cnt <= 3'd0;
        else if (start)
            cnt <= LOAD_VAL;
        else if (cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end

    assign done = (cnt == 3'd0);

endmodule

// File: rtl/slc3_control_unit.sv
// rtl/slc3_control_unit.sv - SLC-3 Moore sequencer; SLC3_PAUSE_EN builds the PAUSE states
module slc3_control_unit
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_al,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE_n,
    output logic       Mem_WE_n
);

    state_t state, next_state;
    logic   wait_start, wait_done;

`ifndef SLC3_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    // Every memory state is entered from a non-memory state, so entry is a state change.
    assign wait_start = is_mem_state(next_state) && (next_state != state);

    slc3_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
        .Clk      (Clk),
        .Reset_al (Reset_al),
        .start    (wait_start),
        .done     (wait_done)
    );

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al)
            state <= S_HALTED;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = ADDR1_PC;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALU_ADD;
        MIO_EN     = 1'b0;
        Mem_OE_n   = 1'b1;
        Mem_WE_n   = 1'b1;

        case (state)
            S_HALTED: if (Run) next_state = S_F1;
            S_F1: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC;
                next_state = S_F2;
            end
            S_F2: begin
                Mem_OE_n = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1;
                if (wait_done) next_state = S_F3;
            end
            S_F3: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
                next_state = S_DEC;
            end
            S_DEC: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   next_state = S_ADD;
                    OP_AND:   next_state = S_AND;
                    OP_NOT:   next_state = S_NOT;
                    OP_BR:    next_state = S_BR_CHK;
                    OP_JMP:   next_state = S_JMP;
                    OP_JSR:   next_state = S_JSR1;
                    OP_LDR:   next_state = S_LDR1;
                    OP_STR:   next_state = S_STR1;
`ifdef SLC3_PAUSE_EN
                    OP_PAUSE: next_state = S_PAUSE1;
`endif
                    default:  next_state = S_F1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR2MUX = IR_5;
                ALUK = (state == S_ADD) ? ALU_ADD : (state == S_AND) ? ALU_AND : ALU_NOT;
                next_state = S_F1;
            end
            S_BR_CHK: next_state = BEN ? S_BR_TAKE : S_F1;
            S_BR_TAKE: begin
                ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                next_state = S_F1;
            end
            S_JMP: begin
                ALUK = ALU_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS; LD_PC = 1'b1;
                next_state = S_F1;
            end
            S_JSR1: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
                next_state = S_JSR2;
            end
            S_JSR2: begin
                LD_PC = 1'b1;
                if (IR_11) begin
                    ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF11; PCMUX = PCMUX_ADDER;
                end else begin
                    ALUK = ALU_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS;
                end
                next_state = S_F1;
            end
            S_LDR1, S_STR1: begin
                ADDR1MUX = ADDR1_BASER; ADDR2MUX = ADDR2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1;
                next_state = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR2: begin
                Mem_OE_n = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1;
                if (wait_done) next_state = S_LDR3;
            end
            S_LDR3: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                next_state = S_F1;
            end
            S_STR2: begin
                SR1MUX = 1'b1; ALUK = ALU_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
                next_state = S_STR3;
            end
            S_STR3: begin
                Mem_WE_n = 1'b0;
                if (wait_done) next_state = S_F1;
            end
`ifdef SLC3_PAUSE_EN
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) next_state = S_PAUSE2;
            end
            S_PAUSE2: if (!Continue) next_state = S_F1;
`endif
            default: next_state = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_unit.sv
// tb/tb_slc3_control_unit.sv - directed bench for slc3_control_unit (default build, MEM_WAIT 2 and 3)
`define SLC3_CONN(o, rst, run) \
    .Clk(Clk), .Reset_al(rst), .Run(run), .Continue(Continue), .Opcode(Opcode), \
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), \
    .GatePC(o[0]), .GateMDR(o[1]), .GateALU(o[2]), .GateMARMUX(o[3]), \
    .LD_MAR(o[4]), .LD_MDR(o[5]), .LD_IR(o[6]), .LD_BEN(o[7]), .LD_CC(o[8]), \
    .LD_REG(o[9]), .LD_PC(o[10]), .LD_LED(o[11]), .PCMUX(o[13:12]), .DRMUX(o[14]), \
    .SR1MUX(o[15]), .SR2MUX(o[16]), .ADDR1MUX(o[17]), .ADDR2MUX(o[19:18]), \
    .ALUK(o[21:20]), .MIO_EN(o[22]), .Mem_OE_n(o[23]), .Mem_WE_n(o[24])

module tb_slc3_control_unit;

    localparam logic [24:0] B_GPC   = 25'd1 << 0;
    localparam logic [24:0] B_GMDR  = 25'd1 << 1;
    localparam logic [24:0] B_GALU  = 25'd1 << 2;
    localparam logic [24:0] B_GMAR  = 25'd1 << 3;
    localparam logic [24:0] B_LMAR  = 25'd1 << 4;
    localparam logic [24:0] B_LMDR  = 25'd1 << 5;
    localparam logic [24:0] B_LIR   = 25'd1 << 6;
    localparam logic [24:0] B_LBEN  = 25'd1 << 7;
    localparam logic [24:0] B_LCC   = 25'd1 << 8;
    localparam logic [24:0] B_LREG  = 25'd1 << 9;
    localparam logic [24:0] B_LPC   = 25'd1 << 10;
    localparam logic [24:0] B_DR    = 25'd1 << 14;
    localparam logic [24:0] B_SR1   = 25'd1 << 15;
    localparam logic [24:0] B_SR2   = 25'd1 << 16;
    localparam logic [24:0] B_A1    = 25'd1 << 17;
    localparam logic [24:0] B_MIO   = 25'd1 << 22;
    localparam logic [24:0] B_OE    = 25'd1 << 23;
    localparam logic [24:0] B_WE    = 25'd1 << 24;

    localparam logic [24:0] V_IDLE  = B_OE | B_WE;
    localparam logic [24:0] V_F1    = V_IDLE | B_GPC | B_LMAR | B_LPC;
    localparam logic [24:0] V_RD    = B_WE | B_MIO | B_LMDR;
    localparam logic [24:0] V_F3    = V_IDLE | B_GMDR | B_LIR;
    localparam logic [24:0] V_DEC   = V_IDLE | B_LBEN;
    localparam logic [24:0] V_ADDI  = V_IDLE | B_GALU | B_LREG | B_LCC | B_SR2;
    localparam logic [24:0] V_ANDR  = V_IDLE | B_GALU | B_LREG | B_LCC | (25'd1 << 20);
    localparam logic [24:0] V_BRT   = V_IDLE | (25'd1 << 12) | (25'd2 << 18) | B_LPC;
    localparam logic [24:0] V_JMP   = V_IDLE | B_GALU | (25'd3 << 20) | (25'd2 << 12) | B_LPC;
    localparam logic [24:0] V_JSR1  = V_IDLE | B_GPC | B_DR | B_LREG;
    localparam logic [24:0] V_JSR2  = V_IDLE | (25'd1 << 12) | (25'd3 << 18) | B_LPC;
    localparam logic [24:0] V_ADR6  = V_IDLE | B_GMAR | B_LMAR | B_A1 | (25'd1 << 18);
    localparam logic [24:0] V_LDR3  = V_IDLE | B_GMDR | B_LREG | B_LCC;
    localparam logic [24:0] V_STR2  = V_IDLE | B_SR1 | (25'd3 << 20) | B_GALU | B_LMDR;
    localparam logic [24:0] V_WR    = B_OE;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst2, rst3, run2, run3, Continue, IR_5, IR_11, BEN;
    logic [3:0]  Opcode;
    logic [24:0] o2, o3;
    int          total = 0;
    int          fails = 0;

    slc3_control_unit #(.MEM_WAIT(2)) dut2 (`SLC3_CONN(o2, rst2, run2));
    slc3_control_unit #(.MEM_WAIT(3)) dut3 (`SLC3_CONN(o3, rst3, run3));

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [24:0] cur(input bit sel);
        return sel ? o3 : o2;
    endfunction

    task automatic fetch(input bit sel, input int w, input string tag);
        for (int i = 0; i < w; i++) begin
            step(); chk({tag, "_F2"}, cur(sel), V_RD);
        end
        step(); chk({tag, "_F3"}, cur(sel), V_F3);
        step(); chk({tag, "_DEC"}, cur(sel), V_DEC);
    endtask

    initial begin
        rst2 = 1'b0; rst3 = 1'b0; run2 = 1'b0; run3 = 1'b0; Continue = 1'b0;
        Opcode = 4'b0001; IR_5 = 1'b1; IR_11 = 1'b1; BEN = 1'b0;
        step(); step();
        chk("reset_w2", o2, V_IDLE);
        chk("reset_w3", o3, V_IDLE);

        rst2 = 1'b1;
        step(); chk("halted_hold", o2, V_IDLE);
        run2 = 1'b1;
        step(); run2 = 1'b0; chk("start_F1", o2, V_F1);
        step(); chk("midF2", o2, V_RD);
        rst2 = 1'b0;
        #1 chk("async_reset", o2, V_IDLE);
        step(); chk("reset_held", o2, V_IDLE);
        rst2 = 1'b1; run2 = 1'b1;
        step(); run2 = 1'b0; chk("restart_F1", o2, V_F1);

        Opcode = 4'b0001; IR_5 = 1'b1;
        fetch(0, 2, "add");
        step(); chk("add_imm", o2, V_ADDI);
        step(); chk("add_F1", o2, V_F1);

        Opcode = 4'b0000; BEN = 1'b0;
        fetch(0, 2, "brn");
        step(); chk("brn_chk", o2, V_IDLE);
        step(); chk("brn_F1", o2, V_F1);

        BEN = 1'b1;
        fetch(0, 2, "brt");
        step(); chk("brt_chk", o2, V_IDLE);
        step(); chk("brt_take", o2, V_BRT);
        step(); chk("brt_F1", o2, V_F1);

        Opcode = 4'b1100;
        fetch(0, 2, "jmp");
        step(); chk("jmp", o2, V_JMP);
        step(); chk("jmp_F1", o2, V_F1);

        Opcode = 4'b0100; IR_11 = 1'b1;
        fetch(0, 2, "jsr");
        step(); chk("jsr1", o2, V_JSR1);
        step(); chk("jsr2", o2, V_JSR2);
        step(); chk("jsr_F1", o2, V_F1);

        Opcode = 4'b0100; IR_11 = 1'b0;
        fetch(0, 2, "jsrr");
        step(); chk("jsrr1", o2, V_JSR1);
        step(); chk("jsrr2", o2, V_JMP);
        step(); chk("jsrr_F1", o2, V_F1);

        Opcode = 4'b0101; IR_5 = 1'b0;
        fetch(0, 2, "and");
        step(); chk("and_reg", o2, V_ANDR);
        step(); chk("and_F1", o2, V_F1);

        Opcode = 4'b1101;
        fetch(0, 2, "pause_nop");
        step(); chk("pause_nop_F1", o2, V_F1);

        rst3 = 1'b1; run3 = 1'b1;
        step(); run3 = 1'b0; chk("w3_F1", o3, V_F1);
        Opcode = 4'b0110;
        fetch(1, 3, "ldr");
        step(); chk("ldr1", o3, V_ADR6);
        for (int i = 0; i < 3; i++) begin
            step(); chk("ldr2_read", o3, V_RD);
        end
        step(); chk("ldr3", o3, V_LDR3);
        step(); chk("ldr_F1", o3, V_F1);

        Opcode = 4'b0111;
        fetch(1, 3, "str");
        step(); chk("str1", o3, V_ADR6);
        step(); chk("str2", o3, V_STR2);
        for (int i = 0; i < 3; i++) begin
            step(); chk("str3_write", o3, V_WR);
        end
        step(); chk("str_F1", o3, V_F1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
